// File: rtl/pla_seq_eval_pkg.sv
// Shared types and widths for the sequential PLA evaluator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// The cube table entry layout is fixed here. The top derives its function
// input/output widths from these constants, so every user of the table sees
// the same entry format.
package pla_seq_eval_pkg;

  localparam int PLA_N_IN    = 34;
  localparam int PLA_N_OUT   = 1;
  localparam int PLA_N_CUBES = 64;
  localparam int PLA_ADDR_W  = $clog2(PLA_N_CUBES);
  localparam int PLA_CNT_W   = PLA_ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [PLA_N_IN-1:0]  care;  // 1 = variable appears in the cube
    logic [PLA_N_IN-1:0]  val;   // literal polarity for cared bits
    logic [PLA_N_OUT-1:0] out;   // outputs this cube drives
  } cube_t;

endpackage

// File: rtl/pla_cube_match.sv
// One evaluation lane: tests a single cube against the restricted input vector.
// Latency: combinational.
// Backpressure: none; the lane is a pure function of its inputs.
//
// Ports: x_eff  restricted input vector
//        cube   table entry under test
//        en     lane enable; low when the cube index is past the active count
//        hit_out the cube's output bits when it matches, else zero
module pla_cube_match
  import pla_seq_eval_pkg::*;
(
  input  logic [PLA_N_IN-1:0]  x_eff,
  input  cube_t                cube,
  input  logic                 en,
  output logic [PLA_N_OUT-1:0] hit_out
);

  logic match;

  // A cube with care=0 matches everything.
  assign match   = en && (((x_eff ^ cube.val) & cube.care) == '0);
  assign hit_out = match ? cube.out : '0;

endmodule

// File: rtl/pla_seq_eval.sv
// Table-driven multi-output sum-of-products evaluator with input restriction.
// Latency: accept at t, result valid at t+E+1, E = max(1, ceil(nc/LANES)) or
//          fewer with early exit. Backpressure: result held in DONE until
//          out_ready; in_ready is low from accept until the result is taken.
//
// Ports: clk/rst       clock, synchronous active-high reset
//        cube_*        cube table write port (IDLE only, else dropped + wr_err)
//        num_cubes     active cube count, clamped to N_CUBES, sampled at accept
//        fix_mask/val  restriction applied to x at accept
//        in_valid/in_ready/x      input vector handshake
//        out_valid/out_ready/y    result handshake
//        busy          evaluation in progress
//        wr_err        sticky flag for dropped cube writes
module pla_seq_eval
  import pla_seq_eval_pkg::*;
#(
  parameter int N_CUBES    = PLA_N_CUBES,
  parameter int LANES      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cube_we,
  input  logic [$clog2(N_CUBES)-1:0]   cube_addr,
  input  logic [PLA_N_IN-1:0]          cube_care,
  input  logic [PLA_N_IN-1:0]          cube_val,
  input  logic [PLA_N_OUT-1:0]         cube_out,
  input  logic [$clog2(N_CUBES):0]     num_cubes,
  input  logic [PLA_N_IN-1:0]          fix_mask,
  input  logic [PLA_N_IN-1:0]          fix_val,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PLA_N_IN-1:0]          x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PLA_N_OUT-1:0]         y,
  output logic                         busy,
  output logic                         wr_err
);

  localparam int N_IN   = PLA_N_IN;
  localparam int N_OUT  = PLA_N_OUT;
  localparam int ADDR_W = $clog2(N_CUBES);
  localparam int CNT_W  = ADDR_W + 1;

  state_t            state;
  cube_t             tbl [N_CUBES];
  logic [N_IN-1:0]   x_eff;
  logic [CNT_W-1:0]  nc;
  logic [CNT_W-1:0]  idx;
  logic [N_OUT-1:0]  acc;
  logic [N_OUT-1:0]  acc_next;
  logic [N_OUT-1:0]  y_q;
  logic [N_OUT-1:0]  lane_out [LANES];
  logic              accept;
  logic              wr_ok;
  logic              eval_last;
  cube_t             wr_cube;

  // A write that lands in the accept cycle is parked here and committed once
  // the scan is over, so the evaluation it raced with sees the old table.
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_addr;
  cube_t             pend_cube;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_EVAL);
  assign y         = y_q;

  assign accept  = in_ready && in_valid;
  assign wr_ok   = cube_we && in_ready;
  assign wr_cube = '{care: cube_care, val: cube_val, out: cube_out};

  // idx is always a multiple of LANES below N_CUBES while scanning, so the
  // lane index never wraps past the table.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [CNT_W-1:0] c;
    cube_t            lane_cube;
    assign c         = idx + CNT_W'(k);
    assign lane_cube = tbl[c[ADDR_W-1:0]];
    pla_cube_match u_match (
      .x_eff   (x_eff),
      .cube    (lane_cube),
      .en      (c < nc),
      .hit_out (lane_out[k])
    );
  end

  always_comb begin
    acc_next = acc;
    for (int k = 0; k < LANES; k++) begin
      acc_next = acc_next | lane_out[k];
    end
  end

  assign eval_last = (({1'b0, idx} + (CNT_W + 1)'(LANES)) >= {1'b0, nc}) ||
                     ((EARLY_EXIT != 0) && (&acc_next));

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      y_q      <= '0;
      wr_err   <= 1'b0;
      pend_vld <= 1'b0;
    end else begin
      if (cube_we && !in_ready) begin
        wr_err <= 1'b1;
      end
      if (pend_vld && state != ST_EVAL) begin
        pend_vld <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state    <= ST_EVAL;
            pend_vld <= cube_we;
          end
        end
        ST_EVAL: begin
          if (eval_last) begin
            state <= ST_DONE;
            y_q   <= acc_next;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath; every field is (re)initialised at accept, so no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      x_eff     <= (x & ~fix_mask) | (fix_val & fix_mask);
      nc        <= (num_cubes > CNT_W'(N_CUBES)) ? CNT_W'(N_CUBES) : num_cubes;
      acc       <= '0;
      idx       <= '0;
      pend_addr <= cube_addr;
      pend_cube <= wr_cube;
    end else if (!rst && state == ST_EVAL) begin
      acc <= acc_next;
      idx <= idx + CNT_W'(LANES);
    end
  end

  // Cube table: never reset. A parked write also commits on a reset edge so
  // an accepted write is not lost when the evaluation is aborted.
  always_ff @(posedge clk) begin
    if (pend_vld && (rst || state != ST_EVAL)) begin
      tbl[pend_addr] <= pend_cube;
    end
    if (!rst && wr_ok && !accept) begin
      tbl[cube_addr] <= wr_cube;
    end
  end

endmodule

// File: tb/tb_pla_seq_eval.sv
// Self-checking bench: two instances (early exit on/off) share all inputs.
// A cube-list model computes y and the expected result latency per spec rules.
module tb_pla_seq_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic        cube_we;
  logic [5:0]  cube_addr;
  logic [33:0] cube_care, cube_val;
  logic [0:0]  cube_out;
  logic [6:0]  num_cubes;
  logic [33:0] fix_mask, fix_val, x;
  logic        in_valid, out_ready;
  logic        in_ready1, out_valid1, busy1, wr_err1;
  logic        in_ready0, out_valid0, busy0, wr_err0;
  logic [0:0]  y1, y0;

  always #5 clk = ~clk;

  pla_seq_eval #(.N_CUBES(64), .LANES(4), .EARLY_EXIT(1)) dut1 (
    .clk(clk), .rst(rst), .cube_we(cube_we), .cube_addr(cube_addr),
    .cube_care(cube_care), .cube_val(cube_val), .cube_out(cube_out),
    .num_cubes(num_cubes), .fix_mask(fix_mask), .fix_val(fix_val),
    .in_valid(in_valid), .in_ready(in_ready1), .x(x),
    .out_valid(out_valid1), .out_ready(out_ready), .y(y1),
    .busy(busy1), .wr_err(wr_err1)
  );

  pla_seq_eval #(.N_CUBES(64), .LANES(4), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .cube_we(cube_we), .cube_addr(cube_addr),
    .cube_care(cube_care), .cube_val(cube_val), .cube_out(cube_out),
    .num_cubes(num_cubes), .fix_mask(fix_mask), .fix_val(fix_val),
    .in_valid(in_valid), .in_ready(in_ready0), .x(x),
    .out_valid(out_valid0), .out_ready(out_ready), .y(y0),
    .busy(busy0), .wr_err(wr_err0)
  );

  int total = 0;
  int bad   = 0;

  logic [33:0] m_care [64];
  logic [33:0] m_val  [64];
  logic        m_out  [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit cube_hits(input logic [33:0] xe, input int c);
    return ((xe ^ m_val[c]) & m_care[c]) == 34'd0;
  endfunction

  function automatic logic model_y(input logic [33:0] xv, fm, fv, input int ncv);
    logic [33:0] xe;
    int n;
    logic r;
    xe = (xv & ~fm) | (fv & fm);
    n  = (ncv > 64) ? 64 : ncv;
    r  = 1'b0;
    for (int c = 0; c < n; c++) if (cube_hits(xe, c)) r = r | m_out[c];
    return r;
  endfunction

  // Cycles from the accept cycle to the first out_valid cycle.
  function automatic int model_lat(input logic [33:0] xv, fm, fv, input int ncv, input bit ee);
    logic [33:0] xe;
    int n, groups;
    logic r;
    xe = (xv & ~fm) | (fv & fm);
    n  = (ncv > 64) ? 64 : ncv;
    groups = (n + 3) / 4;
    if (groups == 0) groups = 1;
    if (ee) begin
      r = 1'b0;
      for (int g = 0; g < groups; g++) begin
        for (int c = 4 * g; c < 4 * g + 4 && c < n; c++)
          if (cube_hits(xe, c)) r = r | m_out[c];
        if (r) return g + 2;
      end
    end
    return groups + 1;
  endfunction

  task automatic set_wr(input int a, input logic [33:0] care, val, input logic o);
    cube_addr = 6'(a);
    cube_care = care;
    cube_val  = val;
    cube_out  = o;
  endtask

  task automatic wr_idle(input int a, input logic [33:0] care, val, input logic o);
    set_wr(a, care, val, o);
    cube_we = 1'b1;
    @(negedge clk);
    cube_we = 1'b0;
    m_care[a] = care;
    m_val[a]  = val;
    m_out[a]  = o;
  endtask

  // Issue one vector; wr_at=0 writes in the accept cycle, wr_at>0 writes
  // during cycle t+wr_at (must still be in EVAL), wr_at<0 no write.
  task automatic run(input string tag, input logic [33:0] xv, fm, fv,
                     input int ncv, input int wr_at);
    logic ey, g1, g0;
    int el1, el0, l1, l0;
    ey  = model_y(xv, fm, fv, ncv);
    el1 = model_lat(xv, fm, fv, ncv, 1'b1);
    el0 = model_lat(xv, fm, fv, ncv, 1'b0);
    l1 = 0; l0 = 0; g1 = 1'bx; g0 = 1'bx;
    x = xv; fix_mask = fm; fix_val = fv; num_cubes = 7'(ncv);
    in_valid = 1'b1;
    if (wr_at == 0) cube_we = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cube_we  = 1'b0;
    // Late changes must not disturb the evaluation in flight.
    x = 34'($urandom); fix_mask = 34'($urandom); fix_val = 34'($urandom);
    num_cubes = 7'($urandom);
    for (int k = 1; k <= 100 && (l1 == 0 || l0 == 0); k++) begin
      if (wr_at > 0 && k == wr_at) cube_we = 1'b1;
      if (wr_at > 0 && k == wr_at + 1) cube_we = 1'b0;
      if (l1 == 0 && out_valid1) begin l1 = k; g1 = y1; end
      if (l0 == 0 && out_valid0) begin l0 = k; g0 = y0; end
      @(negedge clk);
    end
    cube_we = 1'b0;
    check({tag, ".y_ee1"}, 64'(g1), 64'(ey));
    check({tag, ".y_ee0"}, 64'(g0), 64'(ey));
    check({tag, ".lat_ee1"}, 64'(l1), 64'(el1));
    check({tag, ".lat_ee0"}, 64'(l0), 64'(el0));
  endtask

  initial begin
    logic        held;
    logic [33:0] rx, rfm;
    int          rnc;

    rst = 1'b1; cube_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_wr(0, '0, '0, 1'b0);
    num_cubes = '0; fix_mask = '0; fix_val = '0; x = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst.in_ready", 64'(in_ready1), 64'd1);
    check("rst.out_valid", 64'(out_valid1), 64'd0);
    check("rst.y", 64'(y1), 64'd0);
    check("rst.busy", 64'(busy1), 64'd0);
    check("rst.wr_err", 64'(wr_err1), 64'd0);

    // Background cubes need x[0]=1, so x with bit 0 clear matches none.
    for (int a = 0; a < 64; a++) wr_idle(a, 34'h1, 34'h1, 1'b1);
    wr_idle(0, 34'h3_0000_0003, 34'h1_0000_0001, 1'b1);

    run("single.hit",  34'h1_0000_0001, '0, '0, 1, -1);
    run("single.miss", 34'h0_0000_0001, '0, '0, 1, -1);
    run("single.fix",  34'h0_0000_0001, 34'h1_0000_0000, 34'h1_0000_0000, 1, -1);

    run("lat.nc64",  34'h0, '0, '0, 64, -1);
    run("lat.nc5",   34'h0, '0, '0, 5, -1);
    run("lat.nc0",   34'h1_0000_0001, '0, '0, 0, -1);
    run("lat.clamp", 34'h0, '0, '0, 100, -1);

    wr_idle(2, 34'h0, 34'h0, 1'b1);
    run("early", 34'h0, '0, '0, 64, -1);

    // Backpressure: result held in DONE while out_ready is low.
    out_ready = 1'b0;
    x = 34'h0; fix_mask = '0; num_cubes = 7'd64; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp.valid", 64'(out_valid1), 64'd1);
    held = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp.y", 64'(y1), 64'(held));
      check("bp.in_ready", 64'(in_ready1), 64'd0);
    end
    repeat (20) @(negedge clk);  // let the no-early-exit instance finish too
    check("bp.y_ee0", 64'(y0), 64'(held));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp.release", 64'(in_ready1), 64'd1);
    check("bp.release_ee0", 64'(in_ready0), 64'd1);
    out_ready = 1'b1;

    wr_idle(2, 34'h1, 34'h1, 1'b1);
    run("idle_wr", 34'h0, '0, '0, 64, -1);

    // Write during EVAL: dropped, flagged.
    set_wr(5, 34'h0, 34'h0, 1'b1);
    run("busy_wr", 34'h0, '0, '0, 64, 3);
    check("busy_wr.err1", 64'(wr_err1), 64'd1);
    check("busy_wr.err0", 64'(wr_err0), 64'd1);
    run("busy_wr.after", 34'h0, '0, '0, 64, -1);

    // Write racing an accept: invisible now, visible next time.
    set_wr(7, 34'h0, 34'h0, 1'b1);
    run("race_wr", 34'h0, '0, '0, 64, 0);
    m_care[7] = 34'h0; m_val[7] = 34'h0; m_out[7] = 1'b1;
    run("race_wr.next", 34'h0, '0, '0, 64, -1);
    wr_idle(7, 34'h1, 34'h1, 1'b1);

    // Reset mid-EVAL, then re-issue.
    wr_idle(40, 34'h20, 34'h20, 1'b1);
    x = 34'h20; fix_mask = '0; num_cubes = 7'd64; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid.out_valid", 64'(out_valid1), 64'd0);
    check("rst_mid.in_ready", 64'(in_ready1), 64'd1);
    check("rst_mid.busy0", 64'(busy0), 64'd0);
    check("rst_mid.wr_err", 64'(wr_err1), 64'd0);
    run("rst_mid.reissue", 34'h20, '0, '0, 64, -1);

    // Randomised tables and vectors with sparse cubes so matches happen.
    for (int i = 0; i < 40; i++) begin
      for (int w = 0; w < 3; w++)
        wr_idle($urandom_range(0, 63),
                34'($urandom) & 34'($urandom) & 34'($urandom) & {2'($urandom), 32'($urandom)},
                {2'($urandom), 32'($urandom)}, 1'($urandom));
      rx  = {2'($urandom), 32'($urandom)};
      rfm = 34'($urandom) & 34'($urandom);
      rnc = $urandom_range(0, 80);
      if (i % 5 == 0) begin
        set_wr($urandom_range(0, 63), 34'($urandom) & 34'($urandom), 34'($urandom), 1'b1);
        run("rand.race", rx, rfm, 34'($urandom), rnc, 0);
        m_care[cube_addr] = cube_care;
        m_val[cube_addr]  = cube_val;
        m_out[cube_addr]  = cube_out[0];
      end else begin
        run("rand", rx, rfm, 34'($urandom), rnc, -1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pla_seq_eval.md
Name: pla_seq_eval

Overview:
- Sequential, table-driven evaluator for a multi-output sum-of-products (PLA) function with variable restriction.
- Software loads a cube table at run time, so one block replaces per-benchmark combinational netlists.
- Each input vector is first restricted: selected variables are forced to constants. The block then scans LANES cubes per cycle, ORs the matches into the outputs, and returns the result over a valid/ready handshake.
- Used in the autosymmetry test harness to evaluate original and restricted functions on the same hardware.

Parameters:
- N_IN, 34, number of function inputs.
- N_OUT, 1, number of function outputs.
- N_CUBES, 64, cube table depth; power of two, ≥ LANES.
- LANES, 4, cubes evaluated per cycle; power of two, divides N_CUBES.
- EARLY_EXIT, 1, finish early once every output is 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- cube_we  in  1  cube table write strobe.
- cube_addr  in  log2(N_CUBES)  cube index to write.
- cube_care  in  N_IN  literal mask; 1 means the variable appears in the cube.
- cube_val  in  N_IN  literal polarity for cared bits.
- cube_out  in  N_OUT  outputs this cube drives.
- num_cubes  in  log2(N_CUBES)+1  active cube count, sampled at input accept.
- fix_mask  in  N_IN  restriction mask; 1 means the variable is forced.
- fix_val  in  N_IN  forced values.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- x  in  N_IN  input vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  N_OUT  function value.
- busy  out  1  evaluation in progress.
- wr_err  out  1  sticky: a cube write was dropped.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - state IDLE; in_ready=1; out_valid=0; y=0; busy=0; wr_err=0.
  - Cube table contents are not reset; only the first num_cubes entries are ever read.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready:
    - latch x_eff = (x & ~fix_mask) | (fix_val & fix_mask);
    - latch nc = min(num_cubes, N_CUBES); clear acc and idx; go to EVAL.
  - EVAL: busy=1, in_ready=0.
    - Lane k checks cube c=idx+k. It matches iff c<nc and ((x_eff ^ val[c]) & care[c])==0.
    - acc_next = acc | OR of cube_out[c] over matching lanes; idx += LANES.
    - Go to DONE when idx+LANES ≥ nc, or when EARLY_EXIT=1 and acc_next is all ones.
  - DONE: out_valid=1, y=acc. On out_valid&out_ready go to IDLE; in_ready rises the next cycle.
    - y holds its value until the next DONE.
- Latency: accept at cycle t; EVAL occupies E = max(1, ceil(nc/LANES)) cycles, or fewer with early exit; out_valid rises at t+E+1.
- nc=0: exactly one EVAL cycle, then y=0.
- num_cubes > N_CUBES is clamped to N_CUBES.
- A cube with care=0 matches every input (tautology).
- Cube writes:
  - Accepted only in IDLE; the entry is written on that edge.
  - A write accepted in the same cycle as an input accept is not visible to that evaluation.
  - cube_we outside IDLE: the write is dropped and wr_err is set. Only rst clears wr_err.
- fix_mask, fix_val and num_cubes matter only in the accept cycle; later changes do not affect an evaluation in progress.
- out_ready held high in DONE gives back-to-back throughput of one result per E+2 cycles.
- rst during EVAL or DONE:
  - return to IDLE next cycle; the result is discarded; out_valid=0.
  - The table is kept, so a re-issued vector gives the same y.

Decomposition:
- Package pla_seq_eval_pkg:
  - state enum (IDLE, EVAL, DONE);
  - cube struct typedef (care, val, out);
  - localparams for address and count widths.
- Sub-module pla_cube_match: combinational, one instance per lane. Inputs are x_eff, a cube struct, and a lane-enable bit; output is the N_OUT contribution.

Test Plan:
- Single-cube restriction: N_IN=34, N_OUT=1, LANES=4.
  - Load cube0 care=0x3_0000_0003, val=0x1_0000_0001, out=1; nc=1; fix_mask=0.
  - x=0x1_0000_0001 → y=1 at t+2.
  - x=0x0_0000_0001 → y=0.
  - Same x with fix_mask=0x1_0000_0000, fix_val=0x1_0000_0000 → y=1.
- Latency sweep, EARLY_EXIT=0, 64 non-matching cubes: nc=64 → out_valid at t+17; nc=5 → t+3; nc=0 → y=0 at t+2.
- Early exit: EARLY_EXIT=1, cube2 is a tautology with out=1, nc=64 → y=1 at t+2. Same setup with EARLY_EXIT=0 → t+17.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → y stable, in_ready=0. Pulse out_ready → in_ready=1 the next cycle.
- Write while busy: cube_we during EVAL → wr_err=1, table unchanged, result identical to a golden model. Write in IDLE → the next evaluation sees the new cube.
- Reset mid-EVAL: assert rst in cycle t+3 with nc=64 → IDLE and out_valid=0 next cycle. The re-issued vector returns the pre-reset golden y.
